// File: rtl/cache_port_arbiter_if.sv
// Request/response and cache-side bundle for cache_port_arbiter.
//   slave  : arbiter view (requests and cache results in; grants, responses, strobes out)
//   master : requester/cache view (the opposite directions)
// Port 0 is instruction fetch and port 1 is load/store.
interface cache_port_arbiter_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned CNTW      = 16
);
  logic                 req0_valid;
  logic                 req0_write;
  logic [DATAWIDTH-1:0] req0_addr;
  logic [DATAWIDTH-1:0] req0_wdata;
  logic                 req0_ready;
  logic                 rsp0_valid;
  logic [DATAWIDTH-1:0] rsp0_rdata;
  logic                 rsp0_hit;

  logic                 req1_valid;
  logic                 req1_write;
  logic [DATAWIDTH-1:0] req1_addr;
  logic [DATAWIDTH-1:0] req1_wdata;
  logic                 req1_ready;
  logic                 rsp1_valid;
  logic [DATAWIDTH-1:0] rsp1_rdata;
  logic                 rsp1_hit;

  logic                 c_read;
  logic                 c_write;
  logic [DATAWIDTH-1:0] c_addr;
  logic [DATAWIDTH-1:0] c_wdata;
  logic [DATAWIDTH-1:0] c_rdata;
  logic                 c_hit;

  logic                 busy;
  logic                 grant_id;
  logic [CNTW-1:0]      hit_cnt;
  logic [CNTW-1:0]      miss_cnt;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  c_rdata, c_hit,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_hit,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_hit,
    output c_read, c_write, c_addr, c_wdata,
    output busy, grant_id, hit_cnt, miss_cnt
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output c_rdata, c_hit,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_hit,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_hit,
    input  c_read, c_write, c_addr, c_wdata,
    input  busy, grant_id, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares a single-ported cache between two requesters, one access at a time,
// with round-robin tie breaking, miss penalty and saturating hit/miss counters.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : cache_port_arbiter_if.slave (requests, responses, cache strobes, status)
module cache_port_arbiter #(
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned CACHE_LAT    = 1,
  parameter int unsigned MISS_PENALTY = 4,
  parameter int unsigned CNTW         = 16
) (
  input  logic                clock,
  input  logic                reset,
  cache_port_arbiter_if.slave bus
);
  localparam int unsigned MAXC = (CACHE_LAT > MISS_PENALTY) ? CACHE_LAT : MISS_PENALTY;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STALL, S_RESP} state_e;

  state_e               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_last_grant, r_grant_id, r_write;
  logic [DATAWIDTH-1:0] r_c_addr, r_c_wdata, r_rdata, r_rsp_rdata;
  logic                 r_hit, r_rsp_hit, r_c_read, r_c_write, r_busy;
  logic                 r_rsp0_valid, r_rsp1_valid;
  logic [CNTW-1:0]      r_hit_cnt, r_miss_cnt;

  logic                 w_grant, w_ready0, w_ready1, w_accept;
  logic                 w_req_write, w_capture, w_rsp_hit;
  logic [DATAWIDTH-1:0] w_req_addr, w_req_wdata, w_rsp_data;

  // Arbitration, acceptance and next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    w_ready0    = (r_state == S_IDLE) && !w_grant && bus.req0_valid;
    w_ready1    = (r_state == S_IDLE) &&  w_grant && bus.req1_valid;
    w_accept    = w_ready0 || w_ready1;
    w_req_write = w_grant ? bus.req1_write : bus.req0_write;
    w_req_addr  = w_grant ? bus.req1_addr  : bus.req0_addr;
    w_req_wdata = w_grant ? bus.req1_wdata : bus.req0_wdata;
    // Cache result is sampled on the last WAIT cycle
    w_capture   = (r_state == S_WAIT) && (r_cnt <= CW'(1));
    w_rsp_hit   = w_capture ? bus.c_hit : r_hit;
    w_rsp_data  = r_write ? '0 : (w_capture ? bus.c_rdata : r_rdata);

    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = CW'(CACHE_LAT);
      end
      S_WAIT: begin
        if (r_cnt <= CW'(1)) begin
          if (bus.c_hit || (MISS_PENALTY == 0)) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_STALL;
            w_cnt_nxt   = CW'(MISS_PENALTY);
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_STALL: begin
        if (r_cnt <= CW'(1)) w_state_nxt = S_RESP;
        else                 w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, request latch, registered outputs and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_write      <= 1'b0;
      r_c_addr     <= '0;
      r_c_wdata    <= '0;
      r_rdata      <= '0;
      r_hit        <= 1'b0;
      r_c_read     <= 1'b0;
      r_c_write    <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_hit    <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_c_read  <= w_accept && !w_req_write;
      r_c_write <= w_accept &&  w_req_write;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_grant_id   <= w_grant;
        r_write      <= w_req_write;
        r_c_addr     <= w_req_addr;
        r_c_wdata    <= w_req_wdata;
      end
      if (w_capture) begin
        r_rdata <= bus.c_rdata;
        r_hit   <= bus.c_hit;
      end
      r_rsp0_valid <= (w_state_nxt == S_RESP) && !r_grant_id;
      r_rsp1_valid <= (w_state_nxt == S_RESP) &&  r_grant_id;
      r_rsp_rdata  <= (w_state_nxt == S_RESP) ? w_rsp_data : '0;
      r_rsp_hit    <= (w_state_nxt == S_RESP) && w_rsp_hit;
      // Counters are visible in the same cycle as the response pulse
      if (w_state_nxt == S_RESP) begin
        if (w_rsp_hit) begin
          if (r_hit_cnt != {CNTW{1'b1}}) r_hit_cnt <= r_hit_cnt + CNTW'(1);
        end else begin
          if (r_miss_cnt != {CNTW{1'b1}}) r_miss_cnt <= r_miss_cnt + CNTW'(1);
        end
      end
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_rdata = r_rsp_rdata;
  assign bus.rsp1_rdata = r_rsp_rdata;
  assign bus.rsp0_hit   = r_rsp_hit;
  assign bus.rsp1_hit   = r_rsp_hit;
  assign bus.c_read     = r_c_read;
  assign bus.c_write    = r_c_write;
  assign bus.c_addr     = r_c_addr;
  assign bus.c_wdata    = r_c_wdata;
  assign bus.busy       = r_busy;
  assign bus.grant_id   = r_grant_id;
  assign bus.hit_cnt    = r_hit_cnt;
  assign bus.miss_cnt   = r_miss_cnt;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: instance A uses the default parameters, instance B uses
// MISS_PENALTY=0 and 2-bit counters. Stimulus pushes expected responses into a per-instance
// queue; a monitor per instance pops and compares on every response pulse.
module tb_cache_port_arbiter;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 1;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    logic          hit;
    int            cyc;
    int unsigned   hcnt;
    int unsigned   mcnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  logic          sel;
  logic          v0, v1, wr0, wr1, chit;
  logic [DW-1:0] a0, a1, d0, d1, crd;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  int unsigned mh_a, mm_a, mh_b, mm_b;

  cache_port_arbiter_if #(.DATAWIDTH(DW), .CNTW(16)) ifa ();
  cache_port_arbiter_if #(.DATAWIDTH(DW), .CNTW(2))  ifb ();

  cache_port_arbiter #(.DATAWIDTH(DW), .CACHE_LAT(LAT), .MISS_PENALTY(4), .CNTW(16)) u_dut_a (
    .clock(clk), .reset(rst_n), .bus(ifa.slave));
  cache_port_arbiter #(.DATAWIDTH(DW), .CACHE_LAT(LAT), .MISS_PENALTY(0), .CNTW(2)) u_dut_b (
    .clock(clk), .reset(rst_n), .bus(ifb.slave));

  assign ifa.req0_valid = v0 & ~sel;
  assign ifa.req1_valid = v1 & ~sel;
  assign ifb.req0_valid = v0 & sel;
  assign ifb.req1_valid = v1 & sel;
  assign ifa.req0_write = wr0;  assign ifb.req0_write = wr0;
  assign ifa.req1_write = wr1;  assign ifb.req1_write = wr1;
  assign ifa.req0_addr  = a0;   assign ifb.req0_addr  = a0;
  assign ifa.req1_addr  = a1;   assign ifb.req1_addr  = a1;
  assign ifa.req0_wdata = d0;   assign ifb.req0_wdata = d0;
  assign ifa.req1_wdata = d1;   assign ifb.req1_wdata = d1;
  assign ifa.c_rdata    = crd;  assign ifb.c_rdata    = crd;
  assign ifa.c_hit      = chit; assign ifb.c_hit      = chit;

  wire          rdy0   = sel ? ifb.req0_ready : ifa.req0_ready;
  wire          rdy1   = sel ? ifb.req1_ready : ifa.req1_ready;
  wire          busy_m = sel ? ifb.busy       : ifa.busy;
  wire          crd_m  = sel ? ifb.c_read     : ifa.c_read;
  wire          cwr_m  = sel ? ifb.c_write    : ifa.c_write;
  wire          gid_m  = sel ? ifb.grant_id   : ifa.grant_id;
  wire [DW-1:0] cad_m  = sel ? ifb.c_addr     : ifa.c_addr;
  wire [DW-1:0] cwd_m  = sel ? ifb.c_wdata    : ifa.c_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    if (ifa.rsp0_valid || ifa.rsp1_valid) begin
      chk("a_rsp_overlap", 64'(ifa.rsp0_valid & ifa.rsp1_valid), 64'd0);
      chk("a_rsp_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_rsp_port",  64'(ifa.rsp1_valid), 64'(ea.port));
        chk("a_rsp_rdata", 64'(ifa.rsp1_valid ? ifa.rsp1_rdata : ifa.rsp0_rdata), 64'(ea.rdata));
        chk("a_rsp_hit",   64'(ifa.rsp1_valid ? ifa.rsp1_hit : ifa.rsp0_hit), 64'(ea.hit));
        chk("a_rsp_cycle", 64'(cyc), 64'(ea.cyc));
        chk("a_hit_cnt",   64'(ifa.hit_cnt), 64'(ea.hcnt));
        chk("a_miss_cnt",  64'(ifa.miss_cnt), 64'(ea.mcnt));
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    if (ifb.rsp0_valid || ifb.rsp1_valid) begin
      chk("b_rsp_overlap", 64'(ifb.rsp0_valid & ifb.rsp1_valid), 64'd0);
      chk("b_rsp_expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_rsp_port",  64'(ifb.rsp1_valid), 64'(eb.port));
        chk("b_rsp_rdata", 64'(ifb.rsp1_valid ? ifb.rsp1_rdata : ifb.rsp0_rdata), 64'(eb.rdata));
        chk("b_rsp_hit",   64'(ifb.rsp1_valid ? ifb.rsp1_hit : ifb.rsp0_hit), 64'(eb.hit));
        chk("b_rsp_cycle", 64'(cyc), 64'(eb.cyc));
        chk("b_hit_cnt",   64'(ifb.hit_cnt), 64'(eb.hcnt));
        chk("b_miss_cnt",  64'(ifb.miss_cnt), 64'(eb.mcnt));
      end
    end
  end

  // Push the expected response; penalty and counter limit depend on the selected instance
  task automatic push_exp(input logic port, input logic wr, input logic [DW-1:0] rdata,
                          input logic hit, input int t);
    exp_t e;
    e.port  = port;
    e.rdata = wr ? '0 : rdata;
    e.hit   = hit;
    if (!sel) begin
      if (hit) mh_a = (mh_a == 32'hFFFF) ? mh_a : mh_a + 1;
      else     mm_a = (mm_a == 32'hFFFF) ? mm_a : mm_a + 1;
      e.cyc  = t + 2 + int'(LAT) + (hit ? 0 : 4);
      e.hcnt = mh_a;
      e.mcnt = mm_a;
      qa.push_back(e);
    end else begin
      if (hit) mh_b = (mh_b == 3) ? mh_b : mh_b + 1;
      else     mm_b = (mm_b == 3) ? mm_b : mm_b + 1;
      e.cyc  = t + 2 + int'(LAT);
      e.hcnt = mh_b;
      e.mcnt = mm_b;
      qb.push_back(e);
    end
  endtask

  // Single-port request from an idle arbiter; checks ready and the ISSUE/WAIT cycles
  task automatic issue(input logic port, input logic wr, input logic [DW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                       input logic hit, input bit expect_rsp, output int t);
    int start;
    int g;
    @(negedge clk);
    crd = rdata; chit = hit;
    if (port) begin v1 = 1'b1; wr1 = wr; a1 = addr; d1 = wdata; end
    else      begin v0 = 1'b1; wr0 = wr; a0 = addr; d0 = wdata; end
    start = cyc;
    #1;
    g = 0;
    while (!(port ? rdy1 : rdy0) && g < 20) begin
      @(negedge clk); #1; g++;
    end
    t = cyc;
    chk("ready_same_cycle", 64'(t - start), 64'd0);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    chk("issue_c_read",  64'(crd_m), 64'(!wr));
    chk("issue_c_write", 64'(cwr_m), 64'(wr));
    chk("issue_c_addr",  64'(cad_m), 64'(addr));
    chk("issue_c_wdata", 64'(cwd_m), 64'(wdata));
    chk("issue_grant",   64'(gid_m), 64'(port));
    chk("issue_busy",    64'(busy_m), 64'd1);
    if (expect_rsp) push_exp(port, wr, rdata, hit, t);
    @(posedge clk); #1;
    chk("wait_strobes",  64'(crd_m | cwr_m), 64'd0);
    chk("wait_c_addr",   64'(cad_m), 64'(addr));
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (busy_m && g < 60) begin
      @(negedge clk); g++;
    end
    chk("idle_reached", 64'(busy_m), 64'd0);
  endtask

  initial begin
    int t;
    int n;
    int g;
    logic p;
    cyc = 0; checks = 0; failures = 0;
    mh_a = 0; mm_a = 0; mh_b = 0; mm_b = 0;
    rst_n = 1'b0; sel = 1'b0;
    v0 = 0; v1 = 0; wr0 = 0; wr1 = 0; chit = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; crd = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy",    64'(ifa.busy), 64'd0);
    chk("rst_strobes", 64'(ifa.c_read | ifa.c_write), 64'd0);
    chk("rst_cnts",    64'({ifa.hit_cnt, ifa.miss_cnt}), 64'd0);
    chk("rst_grant",   64'(ifa.grant_id), 64'd0);
    chk("rst_c_addr",  64'(ifa.c_addr), 64'd0);
    rst_n = 1'b1;

    // 1: port 0 read hit
    issue(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, t);
    wait_idle();
    // 2: port 1 write miss
    issue(1'b1, 1'b1, 32'h200, 32'h55, 32'hCAFEF00D, 1'b0, 1'b1, t);
    wait_idle();

    // 3: both ports valid for six transactions; grants alternate starting with port 0
    @(negedge clk);
    crd = 32'h12345678; chit = 1'b1;
    v0 = 1'b1; v1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; a0 = 32'h10; a1 = 32'h20;
    n = 0; g = 0;
    while (n < 6 && g < 200) begin
      #1;
      if (rdy0 || rdy1) begin
        p = rdy1;
        chk("tie_single_ready", 64'(rdy0 & rdy1), 64'd0);
        chk("tie_grant_order",  64'(p), 64'(n % 2));
        push_exp(p, 1'b0, 32'h12345678, 1'b1, cyc);
        n++;
      end
      if (n < 6) @(negedge clk);
      g++;
    end
    chk("tie_all_granted", 64'(n), 64'd6);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // 4: reset during STALL of a port 0 miss; no response, first tie afterwards to port 0
    issue(1'b0, 1'b0, 32'h300, 32'h0, 32'h0BAD0BAD, 1'b0, 1'b0, t);
    while (cyc < t + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",    64'(ifa.busy), 64'd0);
    chk("abort_strobes", 64'(ifa.c_read | ifa.c_write), 64'd0);
    chk("abort_cnts",    64'({ifa.hit_cnt, ifa.miss_cnt}), 64'd0);
    chk("abort_grant",   64'(ifa.grant_id), 64'd0);
    chk("abort_c_addr",  64'(ifa.c_addr), 64'd0);
    mh_a = 0; mm_a = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    crd = 32'h44444444; chit = 1'b1;
    v0 = 1'b1; v1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; a0 = 32'h400; a1 = 32'h500;
    #1;
    t = cyc;
    chk("post_rst_ready0", 64'(rdy0), 64'd1);
    chk("post_rst_ready1", 64'(rdy1), 64'd0);
    push_exp(1'b0, 1'b0, 32'h44444444, 1'b1, t);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // 5: instance B, 2-bit hit counter saturates at 3
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, 32'h600 + 32'(i), 32'h0, 32'hA0A0_0000 + 32'(i), 1'b1, 1'b1, t);
      wait_idle();
    end
    // 6: instance B, miss with zero penalty responds like a hit
    issue(1'b1, 1'b0, 32'h700, 32'h0, 32'hBEEF0001, 1'b0, 1'b1, t);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
